program_fetch_unit: RTL

Parametrised instruction store and fetch sequencer that replaces the fixed, bench-driven instruction feed in front of `datapath`. Holds a loadable program memory, owns the program counter, and presents one registered instruction per cycle, with stall, relative jump and automatic halt at end of program. Sits between the board/host loader and the datapath's instruction input; PC also drives the seven-segment debug display.

---
 rtl/program_fetch_unit_if.sv | 30 +++
 rtl/program_fetch_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/program_fetch_unit_if.sv
// rtl/program_fetch_unit_if.sv - loader, sequencing and fetch-output bundle for program_fetch_unit
interface program_fetch_unit_if #(
  parameter int IW   = 8,
  parameter int AW   = 8,
  parameter int OFFW = 6
);
  logic            load_valid;
  logic            load_ready;
  logic [AW-1:0]   load_addr;
  logic [IW-1:0]   load_data;
  logic            run;
  logic            stall;
  logic            jump_en;
  logic [OFFW-1:0] jump_offset;
  logic [AW-1:0]   PC;
  logic [IW-1:0]   instruction;
  logic            instr_valid;
  logic            halted;
  logic            fault;

  modport slave (
    input  load_valid, load_addr, load_data, run, stall, jump_en, jump_offset,
    output load_ready, PC, instruction, instr_valid, halted, fault
  );

  modport master (
    output load_valid, load_addr, load_data, run, stall, jump_en, jump_offset,
    input  load_ready, PC, instruction, instr_valid, halted, fault
  );
endinterface

// File: rtl/program_fetch_unit.sv
// rtl/program_fetch_unit.sv - loadable program store with PC sequencing, stall, relative jump and end-of-program halt
module program_fetch_unit #(
  parameter int IW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 64,
  parameter int OFFW  = 6
) (
  input  logic                 _CLK,
  input  logic                 RESET,
  program_fetch_unit_if.slave  bus
);
  localparam int          MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t        state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic          valid;
  logic          halted;
  logic          fault;
  logic [AW:0]   prog_len;

  logic          loading;
  logic          addr_in_range;
  logic          write_ok;
  logic          write_bad;
  logic [AW:0]   addr_ext;
  logic [AW:0]   len_w;
  logic [AW-1:0] offset_ext;
  logic [AW-1:0] next_pc;

  assign loading       = (state != S_RUN);
  assign addr_ext      = {1'b0, bus.load_addr};
  assign addr_in_range = (addr_ext < DEPTH_X);
  assign write_ok      = loading && bus.load_valid && addr_in_range;
  assign write_bad     = loading && bus.load_valid && !addr_in_range;
  // Length as it will be after this edge's write, so a same-edge run sees it.
  assign len_w         = (write_ok && ((addr_ext + (AW+1)'(1)) > prog_len))
                         ? (addr_ext + (AW+1)'(1)) : prog_len;
  assign offset_ext    = bus.jump_en ? AW'($signed(bus.jump_offset)) : '0;
  assign next_pc       = pc + AW'(1) + offset_ext;

  assign bus.load_ready  = loading;
  assign bus.PC          = pc;
  assign bus.instruction = instr;
  assign bus.instr_valid = valid;
  assign bus.halted      = halted;
  assign bus.fault       = fault;

  always_ff @(posedge _CLK) begin
    if (write_ok) begin
      mem[bus.load_addr[MW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge _CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_LOAD;
      pc       <= '0;
      instr    <= '0;
      valid    <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      prog_len <= '0;
    end else begin
      case (state)
        S_LOAD, S_HALT: begin
          prog_len <= len_w;
          if (write_bad) begin
            fault <= 1'b1;
          end
          if (bus.run) begin
            if (len_w == '0) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state  <= S_RUN;
              pc     <= '0;
              // Address-0 write on the run edge has not reached mem yet.
              instr  <= (write_ok && (bus.load_addr == '0)) ? bus.load_data : mem[0];
              valid  <= 1'b1;
              halted <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (!bus.stall) begin
            pc <= next_pc;
            if ({1'b0, next_pc} < prog_len) begin
              instr <= mem[next_pc[MW-1:0]];
            end else begin
              state  <= S_HALT;
              valid  <= 1'b0;
              halted <= 1'b1;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule
